// File: rtl/imem_fetch_controller.sv
// ============================================================================
// Module   : imem_fetch_controller
// Brief    : Loads a byte-streamed program into a 2**ADDR_W x 32 instruction
//            memory, then sequences the PC with stall/branch/jump/HALT control.
//            Optional macro PC_BOUND_CHECK_EN adds a FAULT state on PC wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch_controller #(
    parameter int                ADDR_W    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_load,
    input  logic              run_start,
    input  logic [7:0]        load_byte,
    input  logic              load_valid,
    input  logic              load_last,
    output logic              load_ready,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_wr_addr,
    output logic [31:0]       imem_wr_data,
    output logic [ADDR_W-1:0] instruction_addr,
    input  logic [31:0]       instruction,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_offset,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              cpu_en,
    output logic              halted,
    output logic              fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_HALT  = 3'd3
`ifdef PC_BOUND_CHECK_EN
        , S_FAULT = 3'd4
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] c_one       = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_last_addr = {ADDR_W{1'b1}};

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_next_pc;

    logic [23:0]       r_buf;
    logic [1:0]        r_cnt;
    logic [ADDR_W-1:0] r_waddr;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;

    logic              w_accept;
    logic              w_word_done;
    logic              w_clear_load;
    logic [31:0]       w_word;
    logic              w_is_halt;
    logic [ADDR_W-1:0] w_seq_pc;
    logic [ADDR_W-1:0] w_br_pc;
    logic              w_seq_oob;
    logic              w_br_oob;

`ifdef PC_BOUND_CHECK_EN
    localparam logic [ADDR_W+1:0] c_one_ext = {{(ADDR_W+1){1'b0}}, 1'b1};
    logic [ADDR_W+1:0] w_seq_ext;
    logic [ADDR_W+1:0] w_br_ext;

    // Two guard bits catch both carry-out past the top and underflow below 0.
    always_comb begin
        w_seq_ext = {2'b00, r_pc} + c_one_ext;
        w_br_ext  = {2'b00, r_pc} + c_one_ext
                  + {{2{branch_offset[ADDR_W-1]}}, branch_offset};
        w_seq_pc  = w_seq_ext[ADDR_W-1:0];
        w_br_pc   = w_br_ext[ADDR_W-1:0];
        w_seq_oob = |w_seq_ext[ADDR_W+1:ADDR_W];
        w_br_oob  = |w_br_ext[ADDR_W+1:ADDR_W];
    end
`else
    always_comb begin
        w_seq_pc  = r_pc + c_one;
        w_br_pc   = r_pc + c_one + branch_offset;
        w_seq_oob = 1'b0;
        w_br_oob  = 1'b0;
    end
`endif

    // Left-justify the bytes collected so far; missing low bytes become zero.
    always_comb begin
        w_accept    = (r_state == S_LOAD) && load_valid;
        w_word_done = w_accept && ((r_cnt == 2'd3) || load_last);
        w_word      = {r_buf, load_byte} << {~r_cnt, 3'b000};
        w_is_halt   = (instruction == HALT_WORD);
    end

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_clear_load = 1'b0;
        load_ready   = 1'b0;
        cpu_en       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_load) begin
                    w_next_state = S_LOAD;
                    w_clear_load = 1'b1;
                end else if (run_start) begin
                    w_next_state = S_RUN;
                    w_next_pc    = RESET_PC;
                end
            end
            S_LOAD: begin
                load_ready = 1'b1;
                if (w_word_done && (load_last || (r_waddr == c_last_addr))) begin
                    w_next_state = S_IDLE;
                end
            end
            S_RUN: begin
                cpu_en = !stall && !w_is_halt;
                if (!stall) begin
                    if (w_is_halt) begin
                        w_next_state = S_HALT;
                    end else if (jump_en) begin
                        w_next_pc = jump_target;
                    end else if (branch_taken) begin
`ifdef PC_BOUND_CHECK_EN
                        if (w_br_oob) w_next_state = S_FAULT;
                        else          w_next_pc    = w_br_pc;
`else
                        w_next_pc = w_br_pc;
`endif
                    end else begin
`ifdef PC_BOUND_CHECK_EN
                        if (w_seq_oob) w_next_state = S_FAULT;
                        else           w_next_pc    = w_seq_pc;
`else
                        w_next_pc = w_seq_pc;
`endif
                    end
                end
            end
            S_HALT: begin
                if (start_load) begin
                    w_next_state = S_LOAD;
                    w_clear_load = 1'b1;
                end else if (run_start) begin
                    w_next_state = S_RUN;
                    w_next_pc    = RESET_PC;
                end
            end
`ifdef PC_BOUND_CHECK_EN
            S_FAULT: begin
                if (start_load) begin
                    w_next_state = S_LOAD;
                    w_clear_load = 1'b1;
                end
            end
`endif
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

    // Word write is registered so the strobe lands on the cycle after the final byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf     <= '0;
            r_cnt     <= 2'd0;
            r_waddr   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_word_done;
            if (w_clear_load) begin
                r_buf   <= '0;
                r_cnt   <= 2'd0;
                r_waddr <= '0;
            end else if (w_accept) begin
                r_buf <= {r_buf[15:0], load_byte};
                r_cnt <= w_word_done ? 2'd0 : r_cnt + 2'd1;
                if (w_word_done) begin
                    r_wr_addr <= r_waddr;
                    r_wr_data <= w_word;
                    r_waddr   <= r_waddr + c_one;
                end
            end
        end
    end

    assign imem_wr_en       = r_wr_en;
    assign imem_wr_addr     = r_wr_addr;
    assign imem_wr_data     = r_wr_data;
    assign instruction_addr = r_pc;
    assign halted           = (r_state == S_HALT);
`ifdef PC_BOUND_CHECK_EN
    assign fault            = (r_state == S_FAULT);
`else
    assign fault            = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_controller.sv
// ============================================================================
// Module   : tb_imem_fetch_controller
// Brief    : Directed self-checking bench for imem_fetch_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_load, run_start;
    logic [7:0]  load_byte;
    logic        load_valid, load_last, load_ready;
    logic        imem_wr_en;
    logic [3:0]  imem_wr_addr;
    logic [31:0] imem_wr_data;
    logic [3:0]  instruction_addr;
    logic [31:0] instruction;
    logic        stall, branch_taken, jump_en;
    logic [3:0]  branch_offset, jump_target;
    logic        cpu_en, halted, fault;

    logic [31:0] mem [0:15];
    int          n_checks = 0;
    int          n_errors = 0;
    int          wr_count = 0;
    int          acc_count = 0;

    imem_fetch_controller #(.ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_load(start_load), .run_start(run_start),
        .load_byte(load_byte), .load_valid(load_valid), .load_last(load_last),
        .load_ready(load_ready), .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr),
        .imem_wr_data(imem_wr_data), .instruction_addr(instruction_addr),
        .instruction(instruction), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump_en(jump_en), .jump_target(jump_target),
        .cpu_en(cpu_en), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    // Instruction memory model: synchronous write, combinational read.
    assign instruction = mem[instruction_addr];
    always @(posedge clk) begin
        if (imem_wr_en) begin
            mem[imem_wr_addr] <= imem_wr_data;
            wr_count          <= wr_count + 1;
        end
        if (load_valid && load_ready) acc_count <= acc_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic stream_words(input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] w;
        for (int i = 0; i < 16; i++) begin
            case (i / 4)
                0: w = w0;
                1: w = w1;
                2: w = w2;
                default: w = w3;
            endcase
            load_byte  = w[31 - 8 * (i % 4) -: 8];
            load_valid = 1'b1;
            load_last  = (i == 15);
            @(negedge clk);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    logic [7:0] b8 [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    logic [7:0] b5 [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
    logic [7:0] b4 [4] = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
    int base_wr, base_acc;

    initial begin
        rst_n = 1'b0; start_load = 1'b0; run_start = 1'b0;
        load_byte = 8'h00; load_valid = 1'b0; load_last = 1'b0;
        stall = 1'b0; branch_taken = 1'b0; branch_offset = 4'h0;
        jump_en = 1'b0; jump_target = 4'h0;
        repeat (2) @(negedge clk);
        check("rst_ready",  load_ready, 0);
        check("rst_wr_en",  imem_wr_en, 0);
        check("rst_pc",     instruction_addr, 0);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_halted", halted, 0);
        check("rst_fault",  fault, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two full words, MSB first.
        base_wr = wr_count;
        start_load = 1'b1; @(negedge clk); start_load = 1'b0;
        check("load_ready_on", load_ready, 1);
        for (int i = 0; i < 8; i++) begin
            load_byte = b8[i]; load_valid = 1'b1; load_last = (i == 7);
            @(negedge clk);
            if (i < 7) check("ld8_wr_en", imem_wr_en, (i == 3));
            if (i == 3) begin
                check("ld8_addr0", imem_wr_addr, 0);
                check("ld8_data0", imem_wr_data, 32'h12345678);
            end
        end
        load_valid = 1'b0; load_last = 1'b0;
        check("ld8_wr_en_last", imem_wr_en, 1);
        check("ld8_addr1", imem_wr_addr, 1);
        check("ld8_data1", imem_wr_data, 32'h9ABCDEF0);
        check("ld8_ready_off", load_ready, 0);
        @(negedge clk);
        check("ld8_wr_en_drop", imem_wr_en, 0);
        check("ld8_mem0", mem[0], 32'h12345678);
        check("ld8_mem1", mem[1], 32'h9ABCDEF0);
        check("ld8_nwrites", wr_count - base_wr, 2);

        // Partial final word.
        start_load = 1'b1; @(negedge clk); start_load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load_byte = b5[i]; load_valid = 1'b1; load_last = (i == 4);
            @(negedge clk);
        end
        load_valid = 1'b0; load_last = 1'b0;
        check("part_wr_en", imem_wr_en, 1);
        check("part_addr",  imem_wr_addr, 1);
        check("part_data",  imem_wr_data, 32'hAA000000);
        check("part_ready", load_ready, 0);
        @(negedge clk);
        check("part_mem0", mem[0], 32'h01020304);

        // Overflow: 70 bytes offered, only 64 taken.
        base_wr = wr_count; base_acc = acc_count;
        start_load = 1'b1; @(negedge clk); start_load = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (i == 64) begin
                check("ovf_ready_drop", load_ready, 0);
                check("ovf_wr_en15", imem_wr_en, 1);
                check("ovf_addr15", imem_wr_addr, 15);
            end
            load_byte = 8'(i); load_valid = 1'b1; load_last = 1'b0;
            @(negedge clk);
        end
        load_valid = 1'b0;
        @(negedge clk);
        check("ovf_nwrites",  wr_count - base_wr, 16);
        check("ovf_accepted", acc_count - base_acc, 64);
        check("ovf_mem0",  mem[0],  32'h00010203);
        check("ovf_mem15", mem[15], 32'h3C3D3E3F);

        // Program with HALT at address 3, then run.
        start_load = 1'b1; @(negedge clk); start_load = 1'b0;
        stream_words(32'h11111111, 32'h22222222, 32'h33333333, 32'hFFFFFFFF);
        @(negedge clk);
        check("prog_mem3", mem[3], 32'hFFFFFFFF);
        run_start = 1'b1; @(negedge clk); run_start = 1'b0;
        for (int p = 0; p < 4; p++) begin
            #1;
            check("run_pc", instruction_addr, p);
            check("run_cpu_en", cpu_en, (p != 3));
            @(negedge clk);
        end
        check("halt_flag", halted, 1);
        check("halt_pc", instruction_addr, 3);
        check("halt_cpu_en", cpu_en, 0);
        @(negedge clk);
        check("halt_pc_hold", instruction_addr, 3);

        // Redirect priority.
        run_start = 1'b1; @(negedge clk); run_start = 1'b0;
        check("rd_pc0", instruction_addr, 0);
        repeat (2) @(negedge clk);
        check("rd_pc2", instruction_addr, 2);
        jump_en = 1'b1; jump_target = 4'd9; branch_taken = 1'b1; branch_offset = 4'd4; stall = 1'b1;
        #1 check("rd_stall_cpu_en", cpu_en, 0);
        @(negedge clk);
        check("rd_stall_hold", instruction_addr, 2);
        stall = 1'b0;
        @(negedge clk);
        check("rd_jump", instruction_addr, 9);
        jump_en = 1'b0; branch_offset = 4'hD;
        @(negedge clk);
        check("rd_branch_neg", instruction_addr, 7);
        branch_taken = 1'b0; jump_en = 1'b1; jump_target = 4'd3;
        @(negedge clk);
        jump_en = 1'b0;
        @(negedge clk);
        check("rd_halt_again", halted, 1);

        // Asynchronous reset mid-load, then clean reload.
        start_load = 1'b1; @(negedge clk); start_load = 1'b0;
        load_byte = 8'h55; load_valid = 1'b1; @(negedge clk);
        load_byte = 8'h66; @(negedge clk);
        load_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_ready",   load_ready, 0);
        check("arst_wr_en",   imem_wr_en, 0);
        check("arst_wr_addr", imem_wr_addr, 0);
        check("arst_wr_data", imem_wr_data, 0);
        check("arst_pc",      instruction_addr, 0);
        check("arst_halted",  halted, 0);
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
        start_load = 1'b1; run_start = 1'b1; @(negedge clk);
        start_load = 1'b0; run_start = 1'b0;
        check("both_pulse_load", load_ready, 1);
        for (int i = 0; i < 4; i++) begin
            load_byte = b4[i]; load_valid = 1'b1; load_last = (i == 3);
            @(negedge clk);
        end
        load_valid = 1'b0; load_last = 1'b0;
        check("reload_addr", imem_wr_addr, 0);
        check("reload_data", imem_wr_data, 32'hCAFEBABE);
        @(negedge clk);

        // Sequential step from the top address.
        run_start = 1'b1; @(negedge clk); run_start = 1'b0;
        check("wrap_pc0", instruction_addr, 0);
        jump_en = 1'b1; jump_target = 4'd15;
        @(negedge clk);
        jump_en = 1'b0;
        check("wrap_pc15", instruction_addr, 15);
        @(negedge clk);
`ifdef PC_BOUND_CHECK_EN
        #1;
        check("bound_fault",  fault, 1);
        check("bound_pc",     instruction_addr, 15);
        check("bound_cpu_en", cpu_en, 0);
        run_start = 1'b1; @(negedge clk); run_start = 1'b0;
        check("bound_run_ignored", fault, 1);
`else
        check("wrap_pc_to0", instruction_addr, 0);
        check("wrap_no_fault", fault, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/imem_fetch_controller.md
Name: imem_fetch_controller

Overview:
- Sequencer for the 16-entry, 32-bit instruction memory of the single-cycle MIPS core.
- LOAD phase: accepts a byte stream over a valid/ready handshake, assembles 32-bit words and writes them into instruction memory.
- RUN phase: owns the program counter and drives instruction_addr. Applies stall, branch and jump redirects, and stops on a HALT word.
- Sits between the external loader/host, the instruction memory and the core's control unit.

Parameters:
- ADDR_W, 4, instruction address width; memory depth is 2**ADDR_W words.
- RESET_PC, 0, PC loaded on every entry to RUN.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_load  in  1  single-cycle pulse; begin program load.
- run_start  in  1  single-cycle pulse; begin execution.
- load_byte  in  8  program byte, most significant byte of each word first.
- load_valid  in  1  load_byte is valid.
- load_last  in  1  qualifies the final byte of the program; sampled with load_valid.
- load_ready  out  1  controller accepts a byte this cycle.
- imem_wr_en  out  1  instruction memory write strobe.
- imem_wr_addr  out  ADDR_W  write address.
- imem_wr_data  out  32  write data.
- instruction_addr  out  ADDR_W  fetch address (the PC).
- instruction  in  32  fetched word, combinational from memory.
- stall  in  1  hold the PC this cycle.
- branch_taken  in  1  branch redirect.
- branch_offset  in  ADDR_W  signed word offset, relative to PC+1.
- jump_en  in  1  absolute redirect.
- jump_target  in  ADDR_W  jump address.
- cpu_en  out  1  core may commit state this cycle.
- halted  out  1  HALT state.
- fault  out  1  PC bound fault; see Optional Feature.

Behaviour:
- Reset (asynchronous, any state, including mid-load and mid-run):
  - state goes to IDLE; the partial word buffer and byte count are discarded.
  - load_ready, imem_wr_en, imem_wr_addr, imem_wr_data, cpu_en, halted and fault are all 0.
  - instruction_addr is RESET_PC.
- States: IDLE, LOAD, RUN, HALT, FAULT (FAULT exists only with the feature).
- IDLE:
  - start_load moves to LOAD and clears the word address and byte count.
  - run_start moves to RUN with PC=RESET_PC.
  - If both pulse in the same cycle, start_load wins.
- LOAD:
  - load_ready=1. A byte is accepted on a clock edge where load_valid and load_ready are both 1.
  - Bytes shift into the word buffer MSB-first.
  - On acceptance of the 4th byte: imem_wr_en pulses high for exactly the next cycle, with imem_wr_data=the assembled word and imem_wr_addr=the current word address. The word address then increments.
  - load_ready stays 1 during that write cycle, so back-to-back bytes are legal with zero bubbles.
  - load_last accepted with a partial word: the remaining low bytes are zero-padded and the word is written the next cycle.
  - After load_last, state returns to IDLE.
  - The write to address 2**ADDR_W-1 also returns to IDLE. load_ready drops on the same cycle as that write; excess bytes are never accepted.
  - run_start is ignored in LOAD.
- RUN:
  - instruction_addr is the PC register.
  - cpu_en = !stall and (instruction != HALT_WORD).
  - Next-PC priority: stall (hold) > jump_en (jump_target) > branch_taken (PC+1+branch_offset) > PC+1.
  - All PC arithmetic is modulo 2**ADDR_W.
  - When instruction==HALT_WORD and stall=0: go to HALT, PC holds, cpu_en=0, and branch/jump inputs are ignored.
  - start_load is ignored in RUN.
- HALT:
  - halted=1, cpu_en=0, PC frozen.
  - run_start goes to RUN with PC=RESET_PC.
  - start_load goes to LOAD; start_load has priority if both pulse together.
- imem_wr_en is never asserted outside the cycle immediately following a completed word.

Optional Feature:
- Macro: PC_BOUND_CHECK_EN.
- Defined:
  - In RUN, any non-stalled next-PC computation that wraps past 2**ADDR_W-1 enters FAULT instead of wrapping. This covers sequential increment as well as branch offsets that carry out or underflow.
  - In FAULT: fault=1, cpu_en=0, PC frozen at the offending instruction's address.
  - Leave FAULT only via start_load (to LOAD) or reset; run_start is ignored.
  - Jump targets are always in range and never fault.
- Not defined: PC wraps modulo 2**ADDR_W, fault is tied to 0, and the FAULT state is absent.

Test Plan:
- Load: stream 8 bytes 12 34 56 78 9A BC DE F0, last on byte 8, load_valid held high → writes addr0=32'h12345678, addr1=32'h9ABCDEF0, one cycle after each 4th byte; state back to IDLE; load_ready=0.
- Partial word: load 5 bytes, 5th = AA with load_last → addr1 written with 32'hAA000000.
- Overflow: stream 70 bytes → exactly 16 writes (addr0..addr15); load_ready falls with the addr15 write; bytes 65-70 are not accepted.
- Run: memory holds HALT_WORD at addr 3; pulse run_start → instruction_addr sequence 0,1,2,3, then halted=1, cpu_en=0, instruction_addr held at 3.
- Redirect priority: at PC=2, assert jump_en (target 9), branch_taken (offset +4) and stall together → PC stays 2. Next cycle, stall=0 with jump and branch still asserted → PC=9. Branch alone at PC=9 with offset -3 → PC=7.
- Reset/wrap: assert rst_n=0 mid-load after 2 bytes → outputs zeroed immediately; reload rewrites addr0 cleanly. Run from PC=15 with no branch → PC becomes 0, or with PC_BOUND_CHECK_EN defined → fault=1 and PC holds 15.
